// File: rtl/serial_gate_mac_if.sv
// serial_gate_mac_if: start, term-stream and result handshakes of the serial gate MAC
interface serial_gate_mac_if #(
    parameter int DATA_WIDTH = 16,
    parameter int N_X = 4,
    parameter int N_H = 4
);
    localparam int IW = $clog2(N_X + N_H);
    logic                         start;
    logic                         start_ready;
    logic signed [DATA_WIDTH-1:0] bias;
    logic                         in_valid;
    logic                         in_ready;
    logic signed [DATA_WIDTH-1:0] in_data;
    logic signed [DATA_WIDTH-1:0] in_weight;
    logic [IW-1:0]                term_idx;
    logic                         term_is_h;
    logic                         out_valid;
    logic                         out_ready;
    logic signed [DATA_WIDTH-1:0] out;
    logic                         sat;
    modport master (
        output start, bias, in_valid, in_data, in_weight, out_ready,
        input  start_ready, in_ready, term_idx, term_is_h, out_valid, out, sat
    );
    modport slave (
        input  start, bias, in_valid, in_data, in_weight, out_ready,
        output start_ready, in_ready, term_idx, term_is_h, out_valid, out, sat
    );
endinterface

// File: rtl/serial_gate_mac.sv
// serial_gate_mac: serial dot product W*x + U*h + b with full-precision accumulate and saturated result
module serial_gate_mac #(
    parameter int DATA_WIDTH  = 16,
    parameter int FRACT_WIDTH = 8,
    parameter int N_X         = 4,
    parameter int N_H         = 4,
    parameter int GUARD       = 8
) (
    input logic clk,
    input logic rst,
    serial_gate_mac_if.slave s
);
    localparam int ACC_WIDTH = 2*DATA_WIDTH + GUARD;
    localparam int N_T = N_X + N_H;
    localparam int IW = $clog2(N_T);
    localparam logic signed [ACC_WIDTH-1:0] MAXV = ACC_WIDTH'((64'sd1 <<< (DATA_WIDTH-1)) - 64'sd1);
    localparam logic signed [ACC_WIDTH-1:0] MINV = -MAXV - 1;
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
    state_t state, state_nx;
    logic signed [ACC_WIDTH-1:0] acc, acc_nx, shifted, bias_ext;
    logic signed [2*DATA_WIDTH-1:0] prod;
    logic [IW-1:0] idx, idx_nx;
    logic last, clip;
    assign prod     = s.in_data * s.in_weight;
    assign bias_ext = ACC_WIDTH'(s.bias) <<< FRACT_WIDTH;
    assign last     = idx == IW'(N_T - 1);
    assign shifted  = acc >>> FRACT_WIDTH;
    assign clip     = shifted > MAXV || shifted < MINV;
    assign s.start_ready = state == IDLE;
    assign s.in_ready    = state == ACCUM;
    assign s.out_valid   = state == DONE;
    assign s.term_idx    = idx;
    assign s.term_is_h   = idx >= IW'(N_X);
    assign s.out = state != DONE ? '0 : shifted > MAXV ? MAXV[DATA_WIDTH-1:0] :
                   shifted < MINV ? MINV[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];
    assign s.sat = state == DONE && clip;
    // state, accumulator and term counter registers; reset discards any partial sum
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            idx   <= '0;
        end else begin
            state <= state_nx;
            acc   <= acc_nx;
            idx   <= idx_nx;
        end
    end
    // next-state: load scaled bias on start, accumulate one product per term handshake
    always_comb begin
        state_nx = state;
        acc_nx   = acc;
        idx_nx   = idx;
        case (state)
            IDLE: if (s.start) begin
                state_nx = ACCUM;
                acc_nx   = bias_ext;
                idx_nx   = '0;
            end
            ACCUM: if (s.in_valid) begin
                acc_nx   = acc + prod;
                idx_nx   = last ? '0 : idx + 1'b1;
                state_nx = last ? DONE : ACCUM;
            end
            DONE: if (s.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_serial_gate_mac.sv
// tb_serial_gate_mac: directed and randomized checks of serial_gate_mac against an arithmetic reference
module tb_serial_gate_mac;
    logic clk = 0;
    logic rst;
    int n_vec = 0;
    int n_bad = 0;
    logic signed [15:0] xs [8];
    logic signed [15:0] ws [8];
    logic [15:0] o;
    logic sv;

    always #5 clk = ~clk;

    serial_gate_mac_if #(.DATA_WIDTH(16), .N_X(4), .N_H(4)) bus ();
    serial_gate_mac dut (.clk(clk), .rst(rst), .s(bus));

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] model(input logic signed [15:0] b);
        longint acc;
        acc = longint'(b) * 256;
        for (int k = 0; k < 8; k++) acc += longint'(xs[k]) * longint'(ws[k]);
        acc = acc >>> 8;
        if (acc > 32767) return {1'b1, 16'h7FFF};
        if (acc < -32768) return {1'b1, 16'h8000};
        return {1'b0, acc[15:0]};
    endfunction

    task automatic fill(input logic signed [15:0] x, input logic signed [15:0] w);
        for (int k = 0; k < 8; k++) begin
            xs[k] = x;
            ws[k] = w;
        end
    endtask

    function automatic logic [15:0] rnd(input int mode);
        if (mode == 0) return 16'($urandom);
        if (mode == 1) return 16'($urandom_range(0, 1023)) - 16'd512;
        return $urandom_range(0, 1) ? 16'h7FFF - 16'($urandom_range(0, 3)) : 16'h8000 + 16'($urandom_range(0, 3));
    endfunction

    task automatic do_dot(input logic [15:0] b, input bit rh, input int stall,
                          output logic [15:0] ob, output logic sb);
        logic [16:0] e;
        e = model(b);
        chk("start_ready_idle", 16'(bus.start_ready), 16'd1);
        bus.start = 1;
        bus.bias  = b;
        @(negedge clk);
        bus.start = 0;
        bus.bias  = 16'($urandom);
        chk("in_ready_accum", 16'(bus.in_ready), 16'd1);
        chk("start_ready_accum", 16'(bus.start_ready), 16'd0);
        for (int k = 0; k < 8; k++) begin
            if (rh) repeat ($urandom_range(0, 2)) begin
                bus.in_valid  = 0;
                bus.start     = 1'($urandom);
                bus.in_data   = 16'($urandom);
                bus.in_weight = 16'($urandom);
                @(negedge clk);
            end
            chk("term_idx", 16'(bus.term_idx), 16'(k));
            chk("term_is_h", 16'(bus.term_is_h), 16'(k >= 4));
            chk("out_valid_early", 16'(bus.out_valid), 16'd0);
            bus.in_valid  = 1;
            bus.in_data   = xs[k];
            bus.in_weight = ws[k];
            @(negedge clk);
        end
        bus.in_valid = rh ? 1'($urandom) : 1'b0;
        bus.start    = rh ? 1'($urandom) : 1'b0;
        chk("out_valid_latency", 16'(bus.out_valid), 16'd1);
        chk("in_ready_done", 16'(bus.in_ready), 16'd0);
        chk("start_ready_done", 16'(bus.start_ready), 16'd0);
        chk("term_idx_done", 16'(bus.term_idx), 16'd0);
        repeat (stall) begin
            bus.out_ready = 0;
            @(negedge clk);
            bus.in_valid = 1'($urandom);
            bus.start    = 1'($urandom);
            chk("out_valid_hold", 16'(bus.out_valid), 16'd1);
            chk("out_hold", bus.out, e[15:0]);
            chk("sat_hold", 16'(bus.sat), 16'(e[16]));
            chk("in_ready_hold", 16'(bus.in_ready), 16'd0);
            chk("start_ready_hold", 16'(bus.start_ready), 16'd0);
        end
        chk("out", bus.out, e[15:0]);
        chk("sat", 16'(bus.sat), 16'(e[16]));
        ob = bus.out;
        sb = bus.sat;
        bus.out_ready = 1;
        @(negedge clk);
        bus.out_ready = 0;
        bus.in_valid  = 0;
        bus.start     = 0;
        chk("out_valid_clear", 16'(bus.out_valid), 16'd0);
    endtask

    initial begin
        rst = 1;
        bus.start = 0;
        bus.bias = 0;
        bus.in_valid = 0;
        bus.in_data = 0;
        bus.in_weight = 0;
        bus.out_ready = 0;
        repeat (3) @(negedge clk);
        rst = 0;
        chk("rst_start_ready", 16'(bus.start_ready), 16'd1);
        chk("rst_in_ready", 16'(bus.in_ready), 16'd0);
        chk("rst_out_valid", 16'(bus.out_valid), 16'd0);
        chk("rst_out", bus.out, 16'd0);
        chk("rst_sat", 16'(bus.sat), 16'd0);
        chk("rst_term_idx", 16'(bus.term_idx), 16'd0);

        fill(0, 0);
        xs[0] = 16'h0200; ws[0] = 16'h0180;
        xs[4] = 16'h0100; ws[4] = 16'hFF00;
        do_dot(16'h0080, 0, 0, o, sv);
        chk("basic_out", o, 16'h0280);
        chk("basic_sat", 16'(sv), 16'd0);

        fill(16'h7FFF, 16'h7FFF);
        do_dot(16'h7FFF, 0, 0, o, sv);
        chk("pos_sat_out", o, 16'h7FFF);
        chk("pos_sat_flag", 16'(sv), 16'd1);
        fill(16'h8000, 16'h7FFF);
        do_dot(16'h8000, 0, 0, o, sv);
        chk("neg_sat_out", o, 16'h8000);
        chk("neg_sat_flag", 16'(sv), 16'd1);

        fill(0, 0);
        xs[0] = 16'h0001; ws[0] = 16'hFFFF;
        do_dot(16'h0000, 0, 0, o, sv);
        chk("floor_neg", o, 16'hFFFF);
        ws[0] = 16'h0001;
        do_dot(16'h0000, 0, 0, o, sv);
        chk("floor_pos", o, 16'h0000);

        for (int k = 0; k < 8; k++) begin
            xs[k] = rnd(1);
            ws[k] = rnd(1);
        end
        do_dot(rnd(1), 1, 3, o, sv);

        bus.start = 1;
        bus.bias  = 16'h1234;
        @(negedge clk);
        bus.start = 0;
        for (int k = 0; k < 3; k++) begin
            bus.in_valid  = 1;
            bus.in_data   = 16'h7000;
            bus.in_weight = 16'h7000;
            @(negedge clk);
        end
        rst = 1;
        bus.start = 1;
        @(negedge clk);
        rst = 0;
        bus.start = 0;
        bus.in_valid = 0;
        chk("midrst_start_ready", 16'(bus.start_ready), 16'd1);
        chk("midrst_in_ready", 16'(bus.in_ready), 16'd0);
        chk("midrst_out_valid", 16'(bus.out_valid), 16'd0);
        chk("midrst_out", bus.out, 16'd0);
        chk("midrst_sat", 16'(bus.sat), 16'd0);
        chk("midrst_term_idx", 16'(bus.term_idx), 16'd0);
        for (int k = 0; k < 8; k++) begin
            xs[k] = rnd(1);
            ws[k] = rnd(0);
        end
        do_dot(rnd(0), 0, 0, o, sv);

        for (int n = 0; n < 1000; n++) begin
            int mode;
            mode = $urandom_range(0, 2);
            for (int k = 0; k < 8; k++) begin
                xs[k] = rnd(mode);
                ws[k] = rnd($urandom_range(0, 2));
            end
            do_dot(rnd(mode), 1, $urandom_range(0, 3), o, sv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/serial_gate_mac.md
SERIAL_GATE_MAC -- requirements
Module: serial_gate_mac

Interface
REQ-001 Parameter DATA_WIDTH, default 16, signed fixed-point word width of all data, weight, bias and result ports.
REQ-002 Parameter FRACT_WIDTH, default 8, number of fractional bits in every DATA_WIDTH word.
REQ-003 Parameter N_X, default 4, number of input-vector terms x[i]*W[i] per dot product.
REQ-004 Parameter N_H, default 4, number of hidden-state terms h[j]*U[j] per dot product.
REQ-005 Parameter GUARD, default 8, extra accumulator headroom bits; ACC_WIDTH = 2*DATA_WIDTH+GUARD.
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 start  input  1  request to begin a new dot product.
REQ-009 start_ready  output  1  high when start is accepted this cycle.
REQ-010 bias  input  DATA_WIDTH  signed bias b, sampled on start handshake.
REQ-011 in_valid  input  1  term operands valid.
REQ-012 in_ready  output  1  block accepts a term this cycle.
REQ-013 in_data  input  DATA_WIDTH  signed operand (x[i] for first N_X terms, then h[j]).
REQ-014 in_weight  input  DATA_WIDTH  signed weight (W[i], then U[j]).
REQ-015 term_idx  output  clog2(N_X+N_H)  index of the next term expected, for weight-memory addressing.
REQ-016 term_is_h  output  1  high when term_idx >= N_X.
REQ-017 out_valid  output  1  result valid.
REQ-018 out_ready  input  1  downstream accepts result.
REQ-019 out  output  DATA_WIDTH  signed result = sum(W*x) + sum(U*h) + b, saturated.
REQ-020 sat  output  1  high with out_valid when the result was clipped.

Function
REQ-021 FSM states IDLE, ACCUM, DONE; start_ready = (state==IDLE); in_ready = (state==ACCUM); out_valid = (state==DONE).
REQ-022 IDLE: on start=1, latch bias into accumulator as sign-extended bias << FRACT_WIDTH, clear term_idx to 0, go to ACCUM next cycle.
REQ-023 ACCUM: on in_valid && in_ready, add full-precision signed product in_data*in_weight (2*DATA_WIDTH bits, 2*FRACT_WIDTH fractional) to the ACC_WIDTH accumulator and increment term_idx; no handshake means no change.
REQ-024 When the accepted term has term_idx == N_X+N_H-1, go to DONE on the next cycle; out_valid rises exactly one cycle after the last term handshake.
REQ-025 Result = accumulator arithmetically shifted right by FRACT_WIDTH (floor rounding), then saturated to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]; sat=1 when clipping occurred.
REQ-026 No intermediate per-product truncation; only the final result is rounded.
REQ-027 DONE: out and sat held stable while out_valid && !out_ready; on out_ready go to IDLE next cycle.
REQ-028 start is ignored outside IDLE; in_valid is ignored outside ACCUM; no overlap of consecutive dot products.
REQ-029 Throughput: one term per cycle; N_X+N_H+2 cycles per result minimum (start, terms, done).
REQ-030 term_idx and term_is_h valid in all states; term_idx=0 in IDLE and DONE.

Reset
REQ-031 rst=1 at a clock edge forces state IDLE, accumulator 0, term_idx 0, out 0, sat 0, out_valid 0, in_ready 0, start_ready 1 on the following cycle, regardless of state; partial sums are discarded.
REQ-032 Reset has priority over start and all handshakes in the same cycle.

Verification
REQ-033 N_X=1,N_H=1 Q8.8: start bias=0x0080; terms (0x0200,0x0180),(0x0100,0xFF00) -> out=0x0280, sat=0, out_valid one cycle after second term.
REQ-034 Default params, all 8 terms (0x7FFF,0x7FFF), bias=0x7FFF -> out=0x7FFF, sat=1; all terms (0x8000,0x7FFF), bias=0x8000 -> out=0x8000, sat=1.
REQ-035 Floor rounding: N=1 term (0x0001,0xFFFF), bias 0 -> out=0xFFFF; term (0x0001,0x0001) -> out=0x0000.
REQ-036 Backpressure: in_valid toggled 1/0 between terms and out_ready low 3 cycles -> correct sum, out/sat stable, in_ready and start_ready low throughout DONE.
REQ-037 rst asserted after 3 of 8 terms -> next cycle IDLE, outputs 0; new full dot product afterwards matches reference model exactly.
REQ-038 Random regression: 1000 dot products, random operands and handshakes, compared to a bit-exact model of REQ-025.
